// File: rtl/ifetch_stage.sv
// ifetch_stage: issues the PC to a 1-cycle instruction BRAM and presents the word to decode,
// holding it across stalls; define IFETCH_ADEL_CHECK_EN to flag misaligned/out-of-range fetches.
module ifetch_stage #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          ADDR_W    = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       PC_In,
  input  logic              Stall,
  input  logic              Flush,
  output logic [ADDR_W-1:0] Imem_Addr,
  input  logic [31:0]       Imem_Rdata,
  output logic [31:0]       Instr,
  output logic [31:0]       Instr_PC,
  output logic              Instr_Valid,
  output logic              Exc_AdEL
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state, state_nx;
  logic [31:0] f_pc, hold_reg, word;
  logic f_valid, f_exc, err, take;
  assign take = Flush | ~Stall;
  assign Imem_Addr = ADDR_W'((PC_In - BASE_ADDR) >> 2);
`ifdef IFETCH_ADEL_CHECK_EN
  localparam logic [32:0] TOP = {1'b0, BASE_ADDR} + (33'd4 << ADDR_W);
  assign err = (PC_In[1:0] != 2'b00) | (PC_In < BASE_ADDR) | ({1'b0, PC_In} >= TOP);
`else
  assign err = 1'b0;
`endif
  always_ff @(posedge Clk)
    state <= !Reset ? IDLE : state_nx;
  // the BRAM output moves on while stalled, so the first stalled RUN edge captures it
  always_comb
    state_nx = take ? RUN : (state == RUN ? HOLD : state);
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      f_pc     <= BASE_ADDR;
      f_valid  <= 1'b0;
      f_exc    <= 1'b0;
      hold_reg <= 32'h0;
    end else if (take) begin
      f_pc    <= PC_In;
      f_valid <= 1'b1;
      f_exc   <= err;
    end else if (state == RUN) begin
      hold_reg <= Imem_Rdata;
    end
  end
  always_comb begin
    word        = state == HOLD ? hold_reg : Imem_Rdata;
    Instr_Valid = f_valid & ~f_exc;
    Instr       = Instr_Valid ? word : 32'h0;
    Instr_PC    = f_pc;
    Exc_AdEL    = f_exc;
  end
endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Consumer end of the PC register interface.
- Takes the fetch address the PC presents each cycle and issues it to a synchronous-read instruction BRAM with 1-cycle latency.
- Registers the request and presents the returned word, with its PC, to the decode stage.
- Captures the returned word in a hold register during pipeline stalls, handles flushes, and flags address errors.

Parameters:
- BASE_ADDR, 32'h0000_3000, byte address of instruction memory word 0; also the reset value of Instr_PC.
- ADDR_W, 12, instruction memory word-address width (memory depth 2^ADDR_W words).

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  synchronous, active-low reset (0 = reset).
- PC_In  input  32  fetch address from the PC register output.
- Stall  input  1  hazard stall, the inverse of the PC enable; 1 = decode not accepting.
- Flush  input  1  kill the current request and restart fetch at PC_In.
- Imem_Addr  output  ADDR_W  BRAM word address.
- Imem_Rdata  input  32  BRAM read data; valid 1 cycle after its address.
- Instr  output  32  instruction for decode; 32'h0 (NOP) when not valid.
- Instr_PC  output  32  byte address of Instr.
- Instr_Valid  output  1  Instr holds a real fetched word.
- Exc_AdEL  output  1  fetch address error for Instr_PC.

Behaviour:
- Imem_Addr is combinational: (PC_In - BASE_ADDR)[ADDR_W+1:2]. The BRAM is read every cycle; there is no enable.
- Registers: F_PC (32), F_Valid, F_Exc, hold_reg (32), state.
- States: IDLE (no request outstanding), RUN (output taken from Imem_Rdata), HOLD (output taken from hold_reg).
- Reset=0 at a posedge:
  - state <= IDLE, F_PC <= BASE_ADDR, F_Valid <= 0, F_Exc <= 0, hold_reg <= 0.
  - This applies from any state, including mid-HOLD.
- Reset=1 at a posedge, priority Flush > Stall:
  - Flush=1 (Stall ignored): F_PC <= PC_In, F_Valid <= 1, F_Exc <= err(PC_In), state <= RUN, hold_reg unchanged. The word for PC_In appears in the next cycle.
  - Stall=1, Flush=0:
    - RUN: hold_reg <= Imem_Rdata, state <= HOLD.
    - HOLD: no change.
    - IDLE: stays IDLE.
    - F_PC, F_Valid and F_Exc are unchanged in all three cases.
  - Stall=0, Flush=0: F_PC <= PC_In, F_Valid <= 1, F_Exc <= err(PC_In), state <= RUN.
- Output mux:
  - word = (state==HOLD) ? hold_reg : Imem_Rdata.
  - Instr_Valid = F_Valid & ~F_Exc.
  - Instr = Instr_Valid ? word : 32'h0.
  - Instr_PC = F_PC.
  - Exc_AdEL = F_Exc.
- Latency: an address presented on PC_In at cycle t with Stall=0 appears on Instr/Instr_PC in cycle t+1.
- A stall of any length delivers the same Instr/Instr_PC every stalled cycle, even though the BRAM output moves on.
- The first cycle after leaving HOLD delivers the word for the address accepted at the leaving edge. No word is skipped or duplicated.
- After reset: the outputs are 0 / BASE_ADDR / 0 / 0 until the first non-stalled posedge.
- Address wrap: the subtraction is modulo 2^32. The word index is truncated to ADDR_W bits, except as overridden by the optional feature.

Optional Feature:
- Macro IFETCH_ADEL_CHECK_EN.
- Defined: err(a) = (a[1:0] != 0) | (a < BASE_ADDR) | (a >= BASE_ADDR + 4*2^ADDR_W).
  - An erroring fetch asserts Exc_AdEL with Instr_Valid=0 and Instr=0.
  - The erroring fetch follows normal stall/hold/flush rules: Exc_AdEL stays asserted while stalled.
- Not defined: err() is constant 0, Exc_AdEL is tied to 0, and out-of-range addresses alias by truncation.

Test Plan:
- Reset held low 3 cycles with PC_In=0x3008 -> Instr=0, Instr_PC=0x3000, Instr_Valid=0, Exc_AdEL=0. After release with PC_In=0x3000, Stall=0 -> next cycle Instr=mem[0], Instr_PC=0x3000, Valid=1.
- PC_In 0x3000, 0x3004, 0x3008 on consecutive cycles (mem[i]=0x1000_0000+i) -> Instr 0x1000_0000, 0x1000_0001, 0x1000_0002 with matching Instr_PC, one cycle behind.
- While Instr_PC=0x3004: Stall=1 for 4 cycles, PC_In held at 0x3008 -> Instr=0x1000_0001 and Instr_PC=0x3004 for all 4 cycles; first cycle after release shows 0x1000_0002 / 0x3008.
- During HOLD: Flush=1 and Stall=1 together, PC_In=0x3080 -> next cycle state RUN, Instr=mem[0x20], Instr_PC=0x3080; hold_reg content is not used.
- Macro defined: PC_In=0x3002 -> Exc_AdEL=1, Instr=0, Valid=0. PC_In=0x7000 (ADDR_W=12) -> Exc_AdEL=1. Macro undefined: 0x7000 -> Instr=mem[0], Exc_AdEL=0.
- Reset=0 asserted mid-HOLD -> next cycle state IDLE, Valid=0, Instr_PC=0x3000. After release with Stall=1 -> remains IDLE and invalid until Stall drops.
